game_sequencer: RTL

Top-level game-phase controller for Space Invaders. Sequences the game through attract, playing, level-clear and game-over phases. Drives the `gameplay` phase code consumed by `sprite_drawer` and `gameplay`, and the `clear`, `clear_score`, `enable` and `level` controls for `player` and `invaders`. It replaces the constant `enable` tie-off and the free-running `level` net, and keeps a high-score register for display.

---
 rtl/game_sequencer_if.sv | 27 ++
 rtl/game_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/game_sequencer_if.sv
// Phase-controller bundle: frame/input status from the playfield and the
// phase, motion and score controls returned to the sprite logic.
interface game_sequencer_if;
  logic        vsync;
  logic        start_debounced;
  logic [19:0] invaders_array;
  logic [3:0]  invaders_line;
  logic [7:0]  score;
  logic [1:0]  gameplay;
  logic        enable;
  logic        clear;
  logic        clear_score;
  logic [2:0]  level;
  logic [7:0]  hi_score;

  // master: the sequencer itself
  modport master (
    input  vsync, start_debounced, invaders_array, invaders_line, score,
    output gameplay, enable, clear, clear_score, level, hi_score
  );

  // slave: the playfield / display side
  modport slave (
    output vsync, start_debounced, invaders_array, invaders_line, score,
    input  gameplay, enable, clear, clear_score, level, hi_score
  );
endinterface

// File: rtl/game_sequencer.sv
// Game-phase controller: attract -> playing -> level-clear / game-over, with level and high score.
// Start acts two cycles after the button edge, wave/landing one cycle after; no backpressure, all outputs registered.
module game_sequencer #(
  parameter int unsigned LOSE_LINE       = 13,
  parameter int unsigned PAUSE_FRAMES    = 120,
  parameter int unsigned GAMEOVER_FRAMES = 180,
  parameter int unsigned MAX_LEVEL       = 7
) (
  input  logic              clk_36MHz,
  input  logic              reset,
  game_sequencer_if.master  gs
);

  typedef enum logic [1:0] {
    ATTRACT     = 2'b00,
    PLAYING     = 2'b01,
    LEVEL_CLEAR = 2'b10,
    GAME_OVER   = 2'b11
  } state_t;

  localparam logic [7:0] PAUSE_INIT    = 8'(PAUSE_FRAMES);
  localparam logic [7:0] GAMEOVER_INIT = 8'(GAMEOVER_FRAMES);
  localparam logic [2:0] LEVEL_TOP     = 3'(MAX_LEVEL);
  localparam logic [3:0] LOSE_ROW      = 4'(LOSE_LINE);

  state_t     state;
  logic       enable_r;
  logic       clear_r;
  logic       clear_score_r;
  logic [2:0] level_r;
  logic [7:0] hi_score_r;
  logic [7:0] frame_cnt;
  logic       start_q;
  logic       start_rise;
  logic       vsync_q;

  logic       frame_tick;
  logic       wave_done;
  logic       landed;
  logic       last_frame;

  assign frame_tick = ~gs.vsync & vsync_q;
  assign wave_done  = (gs.invaders_array == 20'd0);
  assign landed     = (gs.invaders_line >= LOSE_ROW);
  assign last_frame = frame_tick && (frame_cnt == 8'd1);

  // start_rise is a registered flag, so a start press acts one cycle later
  // than the combinational frame/wave conditions.
  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      state         <= ATTRACT;
      enable_r      <= 1'b0;
      clear_r       <= 1'b0;
      clear_score_r <= 1'b0;
      level_r       <= 3'd0;
      hi_score_r    <= 8'd0;
      frame_cnt     <= 8'd0;
      start_q       <= 1'b1;
      start_rise    <= 1'b0;
      vsync_q       <= 1'b1;
    end else begin
      start_q       <= gs.start_debounced;
      start_rise    <= gs.start_debounced & ~start_q;
      vsync_q       <= gs.vsync;
      clear_r       <= 1'b0;
      clear_score_r <= 1'b0;

      unique case (state)
        ATTRACT: begin
          enable_r <= 1'b0;
          if (start_rise) begin
            state         <= PLAYING;
            enable_r      <= 1'b1;
            level_r       <= 3'd0;
            clear_r       <= 1'b1;
            clear_score_r <= 1'b1;
          end
        end

        PLAYING: begin
          enable_r <= 1'b1;
          if (wave_done) begin
            state     <= LEVEL_CLEAR;
            enable_r  <= 1'b0;
            frame_cnt <= PAUSE_INIT;
          end else if (landed) begin
            state     <= GAME_OVER;
            enable_r  <= 1'b0;
            frame_cnt <= GAMEOVER_INIT;
            if (gs.score > hi_score_r) begin
              hi_score_r <= gs.score;
            end
          end
        end

        LEVEL_CLEAR: begin
          enable_r <= 1'b0;
          if (frame_tick && frame_cnt != 8'd0) begin
            frame_cnt <= frame_cnt - 8'd1;
          end
          if (last_frame) begin
            state    <= PLAYING;
            enable_r <= 1'b1;
            clear_r  <= 1'b1;
            if (level_r < LEVEL_TOP) begin
              level_r <= level_r + 3'd1;
            end
          end
        end

        GAME_OVER: begin
          enable_r <= 1'b0;
          if (frame_tick && frame_cnt != 8'd0) begin
            frame_cnt <= frame_cnt - 8'd1;
          end
          if (last_frame) begin
            state      <= ATTRACT;
            // a press made during the final game-over cycle must not carry into attract
            start_rise <= 1'b0;
          end
        end

        default: begin
          state <= ATTRACT;
        end
      endcase
    end
  end

  assign gs.gameplay    = state;
  assign gs.enable      = enable_r;
  assign gs.clear       = clear_r;
  assign gs.clear_score = clear_score_r;
  assign gs.level       = level_r;
  assign gs.hi_score    = hi_score_r;

endmodule
